gpr_write_arbiter: RTL and testbench
====================================

GPR_WRITE_ARBITER -- requirements
Module: gpr_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set consecutive FIFO-denied cycles before the FIFO head is forced a grant; legal range 1..15.
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL set the multi-cycle result FIFO depth; only 2 is required to be supported.
REQ-003 clock  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 wbValid  in  1  pipeline writeback stage requests a GPR write.
REQ-006 wbId / wbData / wbPc  in  5/32/32  pipeline write register, data, instruction PC.
REQ-007 wbStall  out  1  combinational; pipeline SHALL hold its WB stage while high.
REQ-008 muValid  in  1  multi-cycle unit (mul/div) result valid.
REQ-009 muId / muData / muPc  in  5/32/32  multi-cycle write register, data, PC.
REQ-010 muReady  out  1  combinational; result accepted on posedge when muValid && muReady.
REQ-011 writeEnable / writeId / writeData / pcValue  out  1/5/32/32  registered GPR write-port drive.
REQ-012 pendingMask  out  32  combinational; bit i set when any FIFO entry targets register i.

Function
REQ-013 muReady SHALL equal (FIFO count < FIFO_DEPTH) && !reset; push while full SHALL NOT occur even if a pop happens the same cycle.
REQ-014 Accepted mu results SHALL enter the FIFO; no combinational bypass to the write port.
REQ-015 Each cycle exactly one source SHALL be granted: FIFO head when forced (REQ-017), else pipeline if wbValid, else FIFO head if non-empty, else none.
REQ-016 wbStall SHALL be high iff wbValid && the FIFO head is granted that cycle.
REQ-017 Starvation counter SHALL increment each cycle FIFO is non-empty and not granted, clear on FIFO grant or when empty; count == STARVE_LIMIT forces FIFO grant.
REQ-018 Granted request SHALL appear on writeEnable/writeId/writeData/pcValue at the next posedge (1-cycle latency); writeEnable SHALL be 0 in cycles after a no-grant cycle.
REQ-019 Minimum mu latency: accept at edge t, grant in cycle t..t+1, writeEnable high after edge t+2.
REQ-020 FIFO SHALL pop its head on the same posedge a FIFO grant registers; simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-021 FIFO entries SHALL be written in acceptance order; no reordering within a source.
REQ-022 writeId == 0 requests SHALL be granted and forwarded unchanged; pendingMask[0] SHALL always be 0.
REQ-023 pendingMask SHALL reflect post-edge FIFO contents; WAW ordering across sources is the hazard unit's job via pendingMask.

Reset
REQ-024 When reset is high at posedge: FIFO emptied, starvation counter 0, writeEnable/writeId/writeData/pcValue 0.
REQ-025 While reset is high: muReady 0, wbStall 0, no grant; in-flight FIFO entries SHALL be discarded.
REQ-026 First grant SHALL be possible in the first cycle reset is low.

Configuration
REQ-027 Macro GPR_ARB_STARVE_EN defined: starvation promotion per REQ-017 active.
REQ-028 GPR_ARB_STARVE_EN undefined: strict pipeline priority; counter absent; FIFO granted only when wbValid low; wbStall constant 0.

Verification
REQ-029 Reset then idle 5 cycles -> writeEnable 0, muReady 1, pendingMask 0, wbStall 0.
REQ-030 Lone mu push id 5 data 0x1234 at edge t, wbValid 0 -> writeEnable 1, writeId 5, writeData 0x1234 after edge t+2; pendingMask bit 5 set during cycles t..t+1.
REQ-031 Two mu pushes (ids 3, 4) with wbValid held 1 -> third muValid sees muReady 0; with STARVE_EN and limit 4, id 3 written in 5th stalled cycle with wbStall 1, then pipeline resumes.
REQ-032 Same as REQ-031 without GPR_ARB_STARVE_EN -> ids 3, 4 written only after wbValid drops, in order, wbStall never 1.
REQ-033 FIFO full, pop and muValid same cycle -> no push that cycle (muReady 0), push next cycle; FIFO order id-preserved.
REQ-034 Reset asserted with 2 entries queued -> next cycle writeEnable 0, pendingMask 0, queued writes never emitted.

Source files
------------

// File: rtl/gpr_write_arbiter_if.sv
// Writeback-port bundle between the pipeline WB stage, the multi-cycle unit and
// the GPR write port. The arbiter takes the slave side.
interface gpr_write_arbiter_if;
    logic        wbValid;
    logic [4:0]  wbId;
    logic [31:0] wbData;
    logic [31:0] wbPc;
    logic        wbStall;

    logic        muValid;
    logic [4:0]  muId;
    logic [31:0] muData;
    logic [31:0] muPc;
    logic        muReady;

    logic        writeEnable;
    logic [4:0]  writeId;
    logic [31:0] writeData;
    logic [31:0] pcValue;
    logic [31:0] pendingMask;

    modport slave (
        input  wbValid, wbId, wbData, wbPc,
        input  muValid, muId, muData, muPc,
        output wbStall, muReady,
        output writeEnable, writeId, writeData, pcValue, pendingMask
    );

    modport master (
        output wbValid, wbId, wbData, wbPc,
        output muValid, muId, muData, muPc,
        input  wbStall, muReady,
        input  writeEnable, writeId, writeData, pcValue, pendingMask
    );
endinterface

// File: rtl/gpr_write_arbiter.sv
// GPR write-port arbiter: pipeline writeback versus a small FIFO of multi-cycle results.
// Define GPR_ARB_STARVE_EN to let a starved FIFO head preempt the pipeline.
module gpr_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input logic               clock,
    input logic               reset,
    gpr_write_arbiter_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be within 1..15");
    end
    if (FIFO_DEPTH < 1) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be at least 1");
    end

    // aged marks an entry that has spent one full cycle in the FIFO; only aged
    // heads may be granted, giving the two-edge minimum mu-to-write latency.
    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] data;
        logic [31:0] pc;
        logic        aged;
    } entry_t;

    entry_t        fifo_q [FIFO_DEPTH];
    entry_t        fifo_d [FIFO_DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] wr_idx;

    logic          we_q, we_d;
    logic [4:0]    wid_q, wid_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   wpc_q, wpc_d;

    logic          fifo_empty;
    logic          head_ok;
    logic          force_fifo;
    logic          grant_fifo;
    logic          grant_wb;
    logic          mu_ready;
    logic          push;
    logic [31:0]   pending_mask;

`ifdef GPR_ARB_STARVE_EN
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);
    logic [3:0] starve_q, starve_d;

    assign force_fifo = (starve_q == LIMIT_C);

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || grant_fifo) begin
            starve_d = 4'd0;
        end else if (starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign bus.wbStall = bus.wbValid && grant_fifo;
`else
    assign force_fifo  = 1'b0;
    assign bus.wbStall = 1'b0;
`endif

    assign fifo_empty = (count_q == '0);
    assign head_ok    = !fifo_empty && fifo_q[0].aged;
    assign grant_fifo = !reset && head_ok && (force_fifo || !bus.wbValid);
    assign grant_wb   = !reset && bus.wbValid && !grant_fifo;
    // Readiness looks only at the registered count, so a full FIFO never takes a
    // push even on a cycle where it also pops.
    assign mu_ready   = !reset && (count_q < DEPTH_C);
    assign push       = bus.muValid && mu_ready;

    always_comb begin
        fifo_d  = fifo_q;
        count_d = count_q + CW'(push) - CW'(grant_fifo);
        wr_idx  = count_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_d[i].aged = 1'b1;
        end
        if (grant_fifo) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                fifo_d[i] = fifo_d[i+1];
            end
            wr_idx = count_q - CW'(1);
        end
        if (push) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    fifo_d[i].id   = bus.muId;
                    fifo_d[i].data = bus.muData;
                    fifo_d[i].pc   = bus.muPc;
                    fifo_d[i].aged = 1'b0;
                end
            end
        end
    end

    always_comb begin
        we_d    = grant_wb || grant_fifo;
        wid_d   = wid_q;
        wdata_d = wdata_q;
        wpc_d   = wpc_q;
        if (grant_wb) begin
            wid_d   = bus.wbId;
            wdata_d = bus.wbData;
            wpc_d   = bus.wbPc;
        end else if (grant_fifo) begin
            wid_d   = fifo_q[0].id;
            wdata_d = fifo_q[0].data;
            wpc_d   = fifo_q[0].pc;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                pending_mask[fifo_q[i].id] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        fifo_q <= fifo_d;
        if (reset) begin
            count_q <= '0;
            we_q    <= 1'b0;
            wid_q   <= 5'd0;
            wdata_q <= 32'd0;
            wpc_q   <= 32'd0;
        end else begin
            count_q <= count_d;
            we_q    <= we_d;
            wid_q   <= wid_d;
            wdata_q <= wdata_d;
            wpc_q   <= wpc_d;
        end
    end

    assign bus.muReady     = mu_ready;
    assign bus.writeEnable = we_q;
    assign bus.writeId     = wid_q;
    assign bus.writeData   = wdata_q;
    assign bus.pcValue     = wpc_q;
    assign bus.pendingMask = pending_mask;

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Randomized scoreboard bench for gpr_write_arbiter; the reference model keeps the
// mu results as a queue of arrival-stamped entries and predicts every GPR write.
module tb_gpr_write_arbiter;

    localparam int LIMIT = 4;
`ifdef GPR_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0]  id;
        logic [31:0] data;
        logic [31:0] pc;
        int          arrived;
    } mu_ent_t;

    typedef struct {
        logic [4:0]  id;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpr_write_arbiter_if bus();

    gpr_write_arbiter #(.STARVE_LIMIT(LIMIT), .FIFO_DEPTH(2)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    mu_ent_t model_q[$];
    wr_t     sb_q[$];
    wr_t     mon_e;
    int      starve   = 0;
    int      cyc      = 0;
    int      checks   = 0;
    int      failures = 0;
    bit      mon_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every write-port cycle must match the oldest predicted write, or be idle.
    always @(posedge clk) begin
        cyc++;
        #2;
        if (mon_en) begin
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("wr_en",   bus.writeEnable, 1);
                chk("wr_id",   bus.writeId,     mon_e.id);
                chk("wr_data", bus.writeData,   mon_e.data);
                chk("wr_pc",   bus.pcValue,     mon_e.pc);
            end else begin
                chk("wr_idle", bus.writeEnable, 0);
            end
        end
    end

    task automatic step(input bit r,
                        input bit wv, input logic [4:0] wid, input logic [31:0] wd, input logic [31:0] wp,
                        input bit mv, input logic [4:0] mid, input logic [31:0] md, input logic [31:0] mp);
        logic [31:0] exp_mask;
        bit          ready, head_ok, fg, wg, was_empty;
        wr_t         w;
        mu_ent_t     m;
        @(posedge clk);
        #1;
        rst         = r;
        bus.wbValid = wv;
        bus.wbId    = wid;
        bus.wbData  = wd;
        bus.wbPc    = wp;
        bus.muValid = mv;
        bus.muId    = mid;
        bus.muData  = md;
        bus.muPc    = mp;
        @(negedge clk);
        ready     = !r && (model_q.size() < 2);
        was_empty = (model_q.size() == 0);
        head_ok   = !was_empty && (cyc > model_q[0].arrived);
        fg        = !r && head_ok && ((STARVE_EN && starve >= LIMIT) || !wv);
        wg        = !r && wv && !fg;
        exp_mask  = '0;
        foreach (model_q[i]) exp_mask[model_q[i].id] = 1'b1;
        exp_mask[0] = 1'b0;

        chk("mu_ready", bus.muReady, ready);
        chk("wb_stall", bus.wbStall, wv && fg);
        if (!r) chk("pending_mask", bus.pendingMask, exp_mask);

        if (fg) begin
            w = '{model_q[0].id, model_q[0].data, model_q[0].pc};
            sb_q.push_back(w);
            void'(model_q.pop_front());
        end
        if (wg) begin
            w = '{wid, wd, wp};
            sb_q.push_back(w);
        end
        if (r || was_empty || fg) starve = 0;
        else                      starve++;
        if (mv && ready) begin
            m = '{mid, md, mp, cyc + 1};
            model_q.push_back(m);
        end
        if (r) begin
            model_q.delete();
            starve = 0;
            mon_en = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 32'd0);
    endtask

    initial begin
        bus.wbValid = 1'b0; bus.wbId = '0; bus.wbData = '0; bus.wbPc = '0;
        bus.muValid = 1'b0; bus.muId = '0; bus.muData = '0; bus.muPc = '0;

        step(1, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 32'd0);
        step(1, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 32'd0);
        idle(5);

        // lone mu result, id 5
        step(0, 0, 5'd0, 32'd0, 32'd0, 1, 5'd5, 32'h1234, 32'h100);
        idle(4);

        // two mu results under a continuous pipeline stream; a third is held off
        for (int k = 0; k < 14; k++) begin
            step(0, 1, 5'(k + 16), $urandom, 32'h2000 + 32'(k * 4),
                 k < 8, (k == 0) ? 5'd3 : (k == 1) ? 5'd4 : 5'd7, 32'hA000 + 32'(k), 32'h300 + 32'(k));
        end
        idle(6);

        // full FIFO draining while another mu result waits
        step(0, 1, 5'd20, 32'h11, 32'h400, 1, 5'd8, 32'h88, 32'h500);
        step(0, 1, 5'd21, 32'h12, 32'h404, 1, 5'd9, 32'h99, 32'h504);
        for (int k = 0; k < 4; k++) step(0, 0, 5'd0, 32'd0, 32'd0, 1, 5'd10, 32'hAA, 32'h508);
        idle(4);

        // reset with two entries queued: they must vanish
        step(0, 1, 5'd22, 32'h13, 32'h600, 1, 5'd11, 32'hB1, 32'h700);
        step(0, 1, 5'd23, 32'h14, 32'h604, 1, 5'd12, 32'hB2, 32'h704);
        step(1, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 32'd0);
        idle(5);

        for (int k = 0; k < 500; k++) begin
            step($urandom_range(63) == 0,
                 $urandom_range(9) < 6, 5'($urandom), $urandom, $urandom,
                 $urandom_range(1) == 1, 5'($urandom), $urandom, $urandom);
        end
        idle(8);
        chk("sb_drain", sb_q.size(), 0);
        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
